div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for DIV/DIVU; the producer side of the HI/LO register.
- Execute stage starts it and stalls the pipeline until the result is ready.
- Result presented as {hi = remainder, lo = quotient} with a write-enable toward the HI/LO write path.
- Radix-2 restoring algorithm: one quotient bit per cycle, 32 iterations.

---
 rtl/div_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_div_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider (DIV / DIVU).
//
// Produces {hi = remainder, lo = quotient} for the HI/LO write path. It
// generates one quotient bit per cycle over 32 iterations. While a request
// is pending, the divider stalls the pipeline.
//
// Optional build macro: DIV_BYZERO_FLAG_EN adds the div_zero_o output.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start_i     division request, held by EX until ready_o is seen
//   annul_i     cancel any in-flight division (exception / flush)
//   signed_i    1 = signed DIV, 0 = unsigned DIVU
//   dividend_i  dividend, sampled on accept
//   divisor_i   divisor, sampled on accept
//   hi_o        remainder
//   lo_o        quotient
//   whilo_o     HI/LO write enable (same as ready_o)
//   ready_o     result valid
//   stall_o     stall request to pipeline control
//   div_zero_o  (DIV_BYZERO_FLAG_EN only) divide-by-zero indication
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             whilo_o,
  output logic             ready_o,
`ifdef DIV_BYZERO_FLAG_EN
  output logic             div_zero_o,
`endif
  output logic             stall_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [WIDTH-1:0] rem_r;       // partial remainder (always < divisor, so WIDTH bits suffice)
  logic [WIDTH-1:0] quo_r;       // dividend bits shift out of the top while quotient bits enter at the bottom
  logic [WIDTH-1:0] divisor_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             ready_r;

  logic             accept_s;
  logic             divisor_zero_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   trial_s;
  logic             last_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  // Operand conditioning, iteration datapath and sign fix-up.
  always_comb begin
    accept_s       = start_i & ~annul_i;
    divisor_zero_s = (divisor_i == {WIDTH{1'b0}});
    dvd_neg_s      = signed_i & dividend_i[WIDTH-1];
    dvs_neg_s      = signed_i & divisor_i[WIDTH-1];
    dvd_mag_s      = dvd_neg_s ? ({WIDTH{1'b0}} - dividend_i) : dividend_i;
    dvs_mag_s      = dvs_neg_s ? ({WIDTH{1'b0}} - divisor_i) : divisor_i;
    // The 33-bit shifted remainder takes the next dividend bit. The trial
    // subtraction's top bit is the sign: 1 means restore.
    shift_s        = {rem_r, quo_r[WIDTH-1]};
    trial_s        = shift_s - {1'b0, divisor_r};
    last_s         = (cnt_r == CW'(WIDTH - 1));
    quo_fix_s      = neg_q_r ? ({WIDTH{1'b0}} - quo_r) : quo_r;
    rem_fix_s      = neg_r_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FREE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FREE: begin
        if (accept_s) begin
          if (divisor_zero_s) begin
            state_nxt_s = ST_BYZERO;
          end else begin
            state_nxt_s = ST_ON;
          end
        end else begin
          state_nxt_s = ST_FREE;
        end
      end
      ST_BYZERO: begin
        if (annul_i) begin
          state_nxt_s = ST_FREE;
        end else begin
          state_nxt_s = ST_END;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          state_nxt_s = ST_FREE;
        end else if (last_s) begin
          state_nxt_s = ST_END;
        end else begin
          state_nxt_s = ST_ON;
        end
      end
      ST_END: begin
        if (annul_i || !start_i) begin
          state_nxt_s = ST_FREE;
        end else begin
          state_nxt_s = ST_END;
        end
      end
      default: begin
        state_nxt_s = ST_FREE;
      end
    endcase
  end

  // Operand latch, restoring iterations and registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      divisor_r <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_FREE: begin
          if (accept_s) begin
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= dvd_mag_s;
            divisor_r <= dvs_mag_s;
            neg_q_r   <= dvd_neg_s ^ dvs_neg_s;
            neg_r_r   <= dvd_neg_s;
          end
          cnt_r   <= {CW{1'b0}};
          hi_r    <= {WIDTH{1'b0}};
          lo_r    <= {WIDTH{1'b0}};
          ready_r <= 1'b0;
        end
        ST_BYZERO: begin
          // Zero quotient and remainder; negating zero in END keeps them zero.
          rem_r <= {WIDTH{1'b0}};
          quo_r <= {WIDTH{1'b0}};
        end
        ST_ON: begin
          if (annul_i) begin
            cnt_r <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + 1'b1;
            rem_r <= trial_s[WIDTH] ? shift_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};
          end
        end
        ST_END: begin
          if (start_i && !annul_i) begin
            ready_r <= 1'b1;
            hi_r    <= rem_fix_s;
            lo_r    <= quo_fix_s;
          end else begin
            ready_r <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
          end
        end
        default: begin
          ready_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV_BYZERO_FLAG_EN
  logic zero_path_r;
  logic div_zero_r;

  // Remember a BYZERO pass and raise the flag together with ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_path_r <= 1'b0;
      div_zero_r  <= 1'b0;
    end else begin
      if ((state_r == ST_FREE) && accept_s) begin
        zero_path_r <= divisor_zero_s;
      end
      if ((state_r == ST_END) && start_i && !annul_i) begin
        div_zero_r <= zero_path_r;
      end else begin
        div_zero_r <= 1'b0;
      end
    end
  end

  // The early indication lets control see a zero divisor before accept.
  always_comb begin
    div_zero_o = div_zero_r | ((state_r == ST_FREE) & start_i & divisor_zero_s);
  end
`endif

  // Output drive; stall_o is intentionally combinational.
  always_comb begin
    hi_o    = hi_r;
    lo_o    = lo_r;
    ready_o = ready_r;
    whilo_o = ready_r;
    stall_o = start_i & ~ready_r & ~annul_i;
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, annul_i, signed_i;
  logic [31:0] dividend_i, divisor_i;
  logic [31:0] hi_o, lo_o;
  logic        whilo_o, ready_o, stall_o;
`ifdef DIV_BYZERO_FLAG_EN
  logic        div_zero_o;
`endif

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .whilo_o    (whilo_o),
    .ready_o    (ready_o),
`ifdef DIV_BYZERO_FLAG_EN
    .div_zero_o (div_zero_o),
`endif
    .stall_o    (stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    bit          sgn;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic; signed uses truncating division, remainder takes dividend sign.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      hi = 32'd0;
      lo = 32'd0;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // Counts edges until ready_o, bounded; notes any cycle without stall.
  task automatic wait_ready(output int lat, output bit stall_ok);
    lat = 0;
    stall_ok = 1'b1;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_o === 1'b1) break;
      if (stall_o !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         input logic [31:0] eh, input logic [31:0] el, input int elat,
                         input string tag);
    int lat;
    bit stall_ok;
    @(negedge clk);
    dividend_i = a; divisor_i = b; signed_i = sgn; start_i = 1'b1; annul_i = 1'b0;
    #1;
    chk({tag, " stall_req"}, {31'd0, stall_o}, 32'd1);
`ifdef DIV_BYZERO_FLAG_EN
    chk({tag, " dz_early"}, {31'd0, div_zero_o}, {31'd0, (b == 32'd0)});
`endif
    @(posedge clk);
    #1;
    // Operands must be ignored after accept.
    dividend_i = $urandom; divisor_i = $urandom | 32'd1; signed_i = ~sgn;
    wait_ready(lat, stall_ok);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " hi"}, hi_o, eh);
    chk({tag, " lo"}, lo_o, el);
    chk({tag, " whilo"}, {31'd0, whilo_o}, 32'd1);
    chk({tag, " stall_done"}, {31'd0, stall_o}, 32'd0);
    chk({tag, " stall_wait"}, {31'd0, stall_ok}, 32'd1);
`ifdef DIV_BYZERO_FLAG_EN
    chk({tag, " dz_flag"}, {31'd0, div_zero_o}, {31'd0, (b == 32'd0)});
`endif
    @(posedge clk);
    #1;
    chk({tag, " hold_ready"}, {31'd0, ready_o}, 32'd1);
    chk({tag, " hold_lo"}, lo_o, el);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " clr_ready"}, {31'd0, ready_o}, 32'd0);
    chk({tag, " clr_hi"}, hi_o, 32'd0);
    chk({tag, " clr_lo"}, lo_o, 32'd0);
  endtask

  task automatic run_rand(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic [31:0] eh, el;
    model(a, b, sgn, eh, el);
    run_div(a, b, sgn, eh, el, (b == 32'd0) ? 2 : 33, "rand");
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    bit stall_ok;
    bit whilo_seen;
    logic [31:0] a, b;

    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd2,          32'd14,         33};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  33};
    vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'd1,          32'hFFFF_FFFD,  33};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  33};
    vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0,          33};
    vecs[5] = '{32'h0000_1234,  32'd0,          1'b0, 32'd0,          32'd0,          2};
    vecs[6] = '{32'h0000_1234,  32'd0,          1'b1, 32'd0,          32'd0,          2};
    vecs[7] = '{32'hFFFF_FFFF,  32'h10,         1'b0, 32'hF,          32'h0FFF_FFFF,  33};
    vecs[8] = '{32'd5,          32'd9,          1'b1, 32'd5,          32'd0,          33};

    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    dividend_i = 32'd0; divisor_i = 32'd0;
    #12;
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    chk("reset ready", {31'd0, ready_o}, 32'd0);
    chk("reset whilo", {31'd0, whilo_o}, 32'd0);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_div(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, vecs[i].exp_hi, vecs[i].exp_lo,
              vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Annul at iteration 10 with new operands presented; FREE must re-accept next cycle.
    @(negedge clk);
    dividend_i = 32'h1234_5678; divisor_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'h10;
    #1;
    chk("annul stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    chk("annul whilo", {31'd0, whilo_o}, 32'd0);
    wait_ready(lat, stall_ok);
    chk("annul relat", 32'(lat), 32'd34);
    chk("annul lo", lo_o, 32'h0FFF_FFFF);
    chk("annul hi", hi_o, 32'hF);
    @(negedge clk);
    start_i = 1'b0;

    // Annul in ON with start dropped: no write may ever appear.
    @(negedge clk);
    dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    whilo_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (whilo_o !== 1'b0) whilo_seen = 1'b1;
    end
    chk("annul no_write", {31'd0, whilo_seen}, 32'd0);

    // start and annul together in FREE: annul wins.
    @(negedge clk);
    dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    #1;
    chk("both stall", {31'd0, stall_o}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    run_div(32'd50, 32'd5, 1'b0, 32'd0, 32'd10, 33, "after_both");

    // Asynchronous reset mid-ON.
    @(negedge clk);
    dividend_i = 32'h55; divisor_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0; start_i = 1'b0;
    #1;
    chk("rst_on ready", {31'd0, ready_o}, 32'd0);
    chk("rst_on stall", {31'd0, stall_o}, 32'd0);
    chk("rst_on lo", lo_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset while a result is being presented.
    @(negedge clk);
    dividend_i = 32'd100; divisor_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    wait_ready(lat, stall_ok);
    chk("pre_rst ready", {31'd0, ready_o}, 32'd1);
    #2;
    rst = 1'b0; start_i = 1'b0;
    #1;
    chk("rst_end ready", {31'd0, ready_o}, 32'd0);
    chk("rst_end whilo", {31'd0, whilo_o}, 32'd0);
    chk("rst_end hi", hi_o, 32'd0);
    chk("rst_end lo", lo_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div(32'd200, 32'd9, 1'b0, 32'd2, 32'd22, 33, "post_rst");

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = b & 32'hFF;
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: b = b;
      endcase
      run_rand(a, b, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
